// File: rtl/fifo_pkg.sv
// Shared FIFO definitions: default pointer width, write-control FSM states
// and the binary-to-Gray helper.
package fifo_pkg;

  localparam int unsigned FIFO_SIZE = 4;

  typedef enum logic [1:0] {
    INIT  = 2'd0,
    RUN   = 2'd1,
    STALL = 2'd2
  } wstate_e;

  // Callers zero-extend into 32 bits and cast the result back to their width.
  function automatic logic [31:0] bin2gray(input logic [31:0] bin);
    return bin ^ (bin >> 32'd1);
  endfunction

endpackage

// File: rtl/bin2gray_reg.sv
// Registers the Gray-coded form of the next binary write count, so the Gray
// pointer always tracks the binary counter with no extra cycle of latency.
module bin2gray_reg
  import fifo_pkg::*;
#(
  parameter int SIZE = FIFO_SIZE
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [SIZE-1:0] bin_next,
  output logic [SIZE-1:0] gray
);

  logic [SIZE-1:0] gray_r;

  // Gray pointer register, cleared asynchronously.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      gray_r <= '0;
    end else begin
      gray_r <= SIZE'(bin2gray(32'(bin_next)));
    end
  end

  assign gray = gray_r;

endmodule

// File: rtl/wptr_ctrl.sv
// FIFO write-pointer controller: INIT/RUN/STALL handshake FSM, binary write
// count and Gray pointer. Define WPTR_OVERFLOW_STAT_EN for the overflow stats.
module wptr_ctrl
  import fifo_pkg::*;
#(
  parameter int SIZE = FIFO_SIZE
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            wr_valid,
  output logic            wr_ready,
  input  logic            f_flag,
  output logic [SIZE-1:0] w_pointer,
  output logic            mem_we,
  output logic [SIZE-2:0] mem_waddr
`ifdef WPTR_OVERFLOW_STAT_EN
  ,
  output logic            ovf_sticky,
  output logic [7:0]      ovf_count
`endif
);

  wstate_e         state_r;
  wstate_e         state_next_s;
  logic [SIZE-1:0] wbin_r;
  logic [SIZE-1:0] wbin_next_s;
  logic            wr_ready_s;
  logic            mem_we_s;

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= INIT;
    end else begin
      state_r <= state_next_s;
    end
  end

  // FSM next-state logic.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      INIT: begin
        state_next_s = RUN;
      end
      RUN: begin
        if (f_flag) begin
          state_next_s = STALL;
        end else begin
          state_next_s = RUN;
        end
      end
      STALL: begin
        if (f_flag) begin
          state_next_s = STALL;
        end else begin
          state_next_s = RUN;
        end
      end
      default: begin
        state_next_s = INIT;
      end
    endcase
  end

  // FSM outputs: ready drops the same cycle full appears, so no write slips in.
  always_comb begin
    wr_ready_s = 1'b0;
    mem_we_s   = 1'b0;
    case (state_r)
      RUN: begin
        if (f_flag) begin
          wr_ready_s = 1'b0;
        end else begin
          wr_ready_s = 1'b1;
        end
      end
      INIT: begin
        wr_ready_s = 1'b0;
      end
      STALL: begin
        wr_ready_s = 1'b0;
      end
      default: begin
        wr_ready_s = 1'b0;
      end
    endcase
    if (wr_valid && wr_ready_s && !rst) begin
      mem_we_s = 1'b1;
    end else begin
      mem_we_s = 1'b0;
    end
  end

  // Next binary count: advance only on an accepted write, wrapping naturally.
  always_comb begin
    wbin_next_s = wbin_r;
    if (mem_we_s) begin
      wbin_next_s = wbin_r + SIZE'(1);
    end else begin
      wbin_next_s = wbin_r;
    end
  end

  // Binary write count register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wbin_r <= '0;
    end else begin
      wbin_r <= wbin_next_s;
    end
  end

  bin2gray_reg #(
    .SIZE(SIZE)
  ) u_bin2gray_reg (
    .clk     (clk),
    .rst     (rst),
    .bin_next(wbin_next_s),
    .gray    (w_pointer)
  );

  assign wr_ready  = wr_ready_s;
  assign mem_we    = mem_we_s;
  assign mem_waddr = wbin_r[SIZE-2:0];

`ifdef WPTR_OVERFLOW_STAT_EN
  logic       ovf_sticky_r;
  logic [7:0] ovf_count_r;

  // Overflow statistics: sticky flag and saturating count of writes offered while full.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ovf_sticky_r <= 1'b0;
      ovf_count_r  <= 8'd0;
    end else if (wr_valid && f_flag) begin
      ovf_sticky_r <= 1'b1;
      if (ovf_count_r != 8'hFF) begin
        ovf_count_r <= ovf_count_r + 8'd1;
      end else begin
        ovf_count_r <= ovf_count_r;
      end
    end else begin
      ovf_sticky_r <= ovf_sticky_r;
      ovf_count_r  <= ovf_count_r;
    end
  end

  assign ovf_sticky = ovf_sticky_r;
  assign ovf_count  = ovf_count_r;
`endif

endmodule
